// File: rtl/video_fetch_pkg.sv
// rtl/video_fetch_pkg.sv - shared state codes, line sentinel and vertical scale helpers for the line fetcher
package video_fetch_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ALIGN = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_FETCH = 3'd3;
    localparam logic [2:0] ST_DROP  = 3'd4;

    localparam logic [11:0] LINE_NONE = 12'hFFF;

    localparam logic [1:0] SCALE_X1 = 2'd0;
    localparam logic [1:0] SCALE_X2 = 2'd1;
    localparam logic [1:0] SCALE_X4 = 2'd2;
    localparam logic [1:0] SCALE_X8 = 2'd3;

    function automatic logic [11:0] src_of(input logic [11:0] out_line, input logic [1:0] shift);
        return out_line >> shift;
    endfunction

endpackage

// File: rtl/video_line_fetcher_if.sv
// rtl/video_line_fetcher_if.sv - video stream bundle between the VDMA source and the line fetcher
interface video_line_fetcher_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/line_ring_ram.sv
// rtl/line_ring_ram.sv - simple dual-port line ring storage, write on fetch clock, registered read on scanout clock
module line_ring_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 3840,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_wr_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_clk,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge i_wr_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_rd_clk) begin
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/video_line_fetcher.sv
// rtl/video_line_fetcher.sv - VDMA line fetcher into a NUM_BUFS line ring with vertical repeat; VIDEO_FETCH_STATS_EN adds frame/line statistics
module video_line_fetcher
    import video_fetch_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_WIDTH = 1920,
    parameter int NUM_BUFS  = 2,
    parameter int ADDR_W    = $clog2(MAX_WIDTH),
    parameter int BUF_W     = $clog2(NUM_BUFS)
) (
    input  logic                m_axis_vid_aclk,
    input  logic                aresetn,
    input  logic                rd_clk,
    video_line_fetcher_if.slave m_axis_vid,
    input  logic                req_toggle,
    input  logic [11:0]         req_line,
    input  logic                frame_sync,
    input  logic                vsync_request,
    input  logic [1:0]          scale_y_shift,
    input  logic [BUF_W-1:0]    rd_buf,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                fetch_busy,
    output logic                err_overflow,
    output logic                err_late,
`ifdef VIDEO_FETCH_STATS_EN
    output logic [15:0]         stat_frames,
    output logic [ADDR_W:0]     stat_line_len,
`endif
    input  logic                err_clear
);
    localparam int RAM_DEPTH = NUM_BUFS * MAX_WIDTH;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);

    logic [2:0]        r_state;
    logic              r_tready;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [BUF_W-1:0]  r_wr_buf;
    logic [11:0]       r_last_src;
    logic              r_err_overflow;
    logic              r_err_late;
    logic              r_pend;
    logic [11:0]       r_pend_src;
    logic              r_vsync_pend;

    logic              r_tog_s1, r_tog_s2, r_tog_s3;
    logic              r_frame_s1, r_frame_s2;
    logic [11:0]       r_line_s1, r_line_s2;

    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [BUF_W-1:0]  w_wr_buf_nxt;
    logic [11:0]       w_last_src_nxt;
    logic              w_pend_nxt;
    logic [11:0]       w_pend_src_nxt;
    logic              w_vsync_pend_nxt;
    logic [11:0]       w_take_src;
    logic              w_set_ovf;
    logic              w_set_late;
    logic              w_we;
    logic [BUF_W-1:0]  w_we_buf;
    logic [ADDR_W-1:0] w_we_ptr;
    logic              w_tready_nxt;

    logic              w_beat;
    logic              w_tog_edge;
    logic [11:0]       w_src_line;
    logic              w_due;
    logic              w_mid_tuser;
    logic [RAM_AW-1:0] w_ram_wr_addr;
    logic [RAM_AW-1:0] w_ram_rd_addr;

    // Request toggle, line number and frame_sync cross from rd_clk; req_line is quasi-static around each toggle.
    always_ff @(posedge m_axis_vid_aclk) begin
        r_tog_s1   <= req_toggle;
        r_tog_s2   <= r_tog_s1;
        r_tog_s3   <= r_tog_s2;
        r_frame_s1 <= frame_sync;
        r_frame_s2 <= r_frame_s1;
        r_line_s1  <= req_line;
        r_line_s2  <= r_line_s1;
    end

    assign w_tog_edge  = r_tog_s2 ^ r_tog_s3;
    assign w_src_line  = src_of(r_line_s2, scale_y_shift);
    assign w_due       = w_tog_edge && (w_src_line != r_last_src);
    assign w_beat      = m_axis_vid.tvalid && r_tready;
    assign w_mid_tuser = m_axis_vid.tuser && (r_wr_ptr != '0);

    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_wr_buf_nxt     = r_wr_buf;
        w_last_src_nxt   = r_last_src;
        w_pend_nxt       = r_pend;
        w_pend_src_nxt   = r_pend_src;
        w_vsync_pend_nxt = r_vsync_pend;
        w_take_src       = r_pend_src;
        w_set_ovf        = 1'b0;
        w_set_late       = 1'b0;
        w_we             = 1'b0;
        w_we_buf         = r_wr_buf;
        w_we_ptr         = r_wr_ptr;
        case (r_state)
            ST_IDLE: begin
                w_pend_nxt       = 1'b0;
                w_vsync_pend_nxt = 1'b0;
                if (w_beat && m_axis_vid.tuser) begin
                    w_we         = 1'b1;
                    w_we_buf     = '0;
                    w_we_ptr     = '0;
                    w_wr_buf_nxt = '0;
                    w_wr_ptr_nxt = ADDR_W'(1);
                    w_state_nxt  = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (r_frame_s2) begin
                    w_last_src_nxt = LINE_NONE;
                    w_state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (vsync_request) begin
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (w_due || r_pend) begin
                    w_take_src     = w_due ? w_src_line : r_pend_src;
                    w_wr_buf_nxt   = w_take_src[BUF_W-1:0];
                    w_last_src_nxt = w_take_src;
                    w_wr_ptr_nxt   = '0;
                    w_pend_nxt     = 1'b0;
                    w_state_nxt    = ST_FETCH;
                end
            end
            ST_FETCH, ST_DROP: begin
                if (vsync_request) begin
                    w_vsync_pend_nxt = 1'b1;
                end
                // A new source line while the current one is still streaming is late; remember it for WAIT.
                if (w_due) begin
                    w_set_late     = 1'b1;
                    w_pend_nxt     = 1'b1;
                    w_pend_src_nxt = w_src_line;
                end
                if (w_beat) begin
                    if (r_state == ST_FETCH) begin
                        w_we = 1'b1;
                        if (w_mid_tuser) begin
                            w_we_buf     = '0;
                            w_we_ptr     = '0;
                            w_wr_buf_nxt = '0;
                            w_wr_ptr_nxt = ADDR_W'(1);
                        end else begin
                            w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
                        end
                    end
                    if (m_axis_vid.tlast) begin
                        w_wr_ptr_nxt     = '0;
                        w_vsync_pend_nxt = 1'b0;
                        w_state_nxt      = (r_vsync_pend || vsync_request) ? ST_IDLE : ST_WAIT;
                    end else if (r_state == ST_FETCH && !w_mid_tuser &&
                                 r_wr_ptr == ADDR_W'(MAX_WIDTH - 1)) begin
                        w_set_ovf   = 1'b1;
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_tready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_DROP);
    end

    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            r_state        <= ST_IDLE;
            r_tready       <= 1'b0;
            r_wr_ptr       <= '0;
            r_wr_buf       <= '0;
            r_last_src     <= LINE_NONE;
            r_err_overflow <= 1'b0;
            r_err_late     <= 1'b0;
            r_pend         <= 1'b0;
            r_pend_src     <= LINE_NONE;
            r_vsync_pend   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_tready       <= w_tready_nxt;
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_wr_buf       <= w_wr_buf_nxt;
            r_last_src     <= w_last_src_nxt;
            r_err_overflow <= w_set_ovf | (r_err_overflow & ~err_clear);
            r_err_late     <= w_set_late | (r_err_late & ~err_clear);
            r_pend         <= w_pend_nxt;
            r_pend_src     <= w_pend_src_nxt;
            r_vsync_pend   <= w_vsync_pend_nxt;
        end
    end

`ifdef VIDEO_FETCH_STATS_EN
    logic [15:0]     r_stat_frames;
    logic [ADDR_W:0] r_stat_line_len;

    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            r_stat_frames   <= '0;
            r_stat_line_len <= '0;
        end else begin
            if (w_beat && m_axis_vid.tuser) begin
                r_stat_frames <= r_stat_frames + 16'd1;
            end
            if (w_beat && m_axis_vid.tlast && r_state == ST_FETCH) begin
                r_stat_line_len <= {1'b0, w_we_ptr} + (ADDR_W+1)'(1);
            end
        end
    end

    assign stat_frames   = r_stat_frames;
    assign stat_line_len = r_stat_line_len;
`endif

    // Buffers are MAX_WIDTH apart, so the flat address is a multiply rather than a concatenation.
    assign w_ram_wr_addr = RAM_AW'(w_we_buf) * RAM_AW'(MAX_WIDTH) + RAM_AW'(w_we_ptr);
    assign w_ram_rd_addr = RAM_AW'(rd_buf) * RAM_AW'(MAX_WIDTH) + RAM_AW'(rd_addr);

    line_ring_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (RAM_DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .i_wr_clk  (m_axis_vid_aclk),
        .i_wr_en   (w_we),
        .i_wr_addr (w_ram_wr_addr),
        .i_wr_data (m_axis_vid.tdata),
        .i_rd_clk  (rd_clk),
        .i_rd_addr (w_ram_rd_addr),
        .o_rd_data (rd_data)
    );

    assign m_axis_vid.tready = r_tready;
    assign fetch_busy        = (r_state == ST_FETCH);
    assign err_overflow      = r_err_overflow;
    assign err_late          = r_err_late;
endmodule

// File: tb/tb_video_line_fetcher.sv
// tb/tb_video_line_fetcher.sv - scoreboard bench for the video line fetcher
module tb_video_line_fetcher;
    localparam int DATA_W    = 32;
    localparam int MAX_WIDTH = 1920;
    localparam int NUM_BUFS  = 2;
    localparam int ADDR_W    = $clog2(MAX_WIDTH);
    localparam int BUF_W     = $clog2(NUM_BUFS);

    logic              aclk = 1'b0;
    logic              rd_clk = 1'b0;
    logic              aresetn = 1'b0;
    logic              req_toggle = 1'b0;
    logic [11:0]       req_line = '0;
    logic              frame_sync = 1'b0;
    logic              vsync_request = 1'b0;
    logic [1:0]        scale_y_shift = 2'd0;
    logic [BUF_W-1:0]  rd_buf = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              fetch_busy;
    logic              err_overflow;
    logic              err_late;
    logic              err_clear = 1'b0;

    always #5 aclk = ~aclk;
    always #7 rd_clk = ~rd_clk;

    video_line_fetcher_if #(.DATA_W(DATA_W)) vid ();

    video_line_fetcher #(
        .DATA_W    (DATA_W),
        .MAX_WIDTH (MAX_WIDTH),
        .NUM_BUFS  (NUM_BUFS)
    ) dut (
        .m_axis_vid_aclk (aclk),
        .aresetn         (aresetn),
        .rd_clk          (rd_clk),
        .m_axis_vid      (vid.slave),
        .req_toggle      (req_toggle),
        .req_line        (req_line),
        .frame_sync      (frame_sync),
        .vsync_request   (vsync_request),
        .scale_y_shift   (scale_y_shift),
        .rd_buf          (rd_buf),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .fetch_busy      (fetch_busy),
        .err_overflow    (err_overflow),
        .err_late        (err_late),
        .err_clear       (err_clear)
    );

    int total = 0;
    int bad = 0;
    int fetch_cnt = 0;
    logic busy_q = 1'b0;

    logic [31:0] q_exp[$];
    string       q_name[$];
    logic        rd_tag = 1'b0;
    logic        rd_vld_d = 1'b0;

    always @(negedge aclk) begin
        busy_q <= fetch_busy;
        if (fetch_busy && !busy_q) fetch_cnt <= fetch_cnt + 1;
    end

    always @(posedge rd_clk) rd_vld_d <= rd_tag;

    always @(negedge rd_clk) begin
        if (rd_vld_d) begin
            total++;
            if (q_exp.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected got=%08h exp=none", rd_data);
            end else begin
                logic [31:0] e;
                string       n;
                e = q_exp.pop_front();
                n = q_name.pop_front();
                if (rd_data !== e) begin
                    bad++;
                    $display("FAIL %s got=%08h exp=%08h", n, rd_data, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic do_read(input logic [BUF_W-1:0] b, input logic [ADDR_W-1:0] a,
                           input logic [31:0] exp, input string nm);
        @(negedge rd_clk);
        rd_buf  = b;
        rd_addr = a;
        rd_tag  = 1'b1;
        q_exp.push_back(exp);
        q_name.push_back(nm);
        @(negedge rd_clk);
        rd_tag = 1'b0;
    endtask

    task automatic send_seg(input logic [15:0] tag, input int first, input int n,
                            input bit last, input bit user);
        int   idx = 0;
        int   guard = 0;
        logic rdy;
        while (idx < n && guard <= n + 200) begin
            @(negedge aclk);
            vid.tvalid = 1'b1;
            vid.tdata  = {tag, 16'(first + idx)};
            vid.tlast  = last && (idx == n - 1);
            vid.tuser  = user && (idx == 0);
            rdy = vid.tready;
            @(posedge aclk);
            if (rdy) idx++;
            guard++;
        end
        if (idx < n) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=%0d exp=%0d", idx, n);
        end
        @(negedge aclk);
        vid.tvalid = 1'b0;
        vid.tlast  = 1'b0;
        vid.tuser  = 1'b0;
    endtask

    task automatic req(input logic [11:0] ln);
        @(negedge rd_clk);
        req_line   = ln;
        req_toggle = ~req_toggle;
        repeat (6) @(negedge rd_clk);
    endtask

    task automatic wait_busy(input logic v, input string nm);
        int n = 0;
        while (fetch_busy !== v && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check(nm, 32'(fetch_busy), 32'(v));
    endtask

    initial begin
        int cnt0;
        int drain;
        vid.tvalid = 1'b0;
        vid.tdata  = '0;
        vid.tlast  = 1'b0;
        vid.tuser  = 1'b0;

        repeat (3) @(negedge aclk);
        check("rst_tready", 32'(vid.tready), 32'd0);
        check("rst_busy", 32'(fetch_busy), 32'd0);
        check("rst_errs", {30'd0, err_overflow, err_late}, 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("idle_tready", 32'(vid.tready), 32'd1);

        send_seg(16'h00AA, 0, 1, 1'b0, 1'b1);
        check("align_tready", 32'(vid.tready), 32'd0);
        frame_sync = 1'b1;
        repeat (5) @(negedge aclk);
        check("wait_busy0", 32'(fetch_busy), 32'd0);

        for (int l = 0; l < 4; l++) begin
            req(12'(l));
            wait_busy(1'b1, "line_fetch_start");
            send_seg(16'h0100 + 16'(l), 0, 720, 1'b1, 1'b0);
            check("gap_tready", 32'(vid.tready), 32'd0);
            check("gap_busy", 32'(fetch_busy), 32'd0);
            do_read(BUF_W'(l % 2), 0, {16'h0100 + 16'(l), 16'd0}, "line_w0");
            do_read(BUF_W'(l % 2), 719, {16'h0100 + 16'(l), 16'd719}, "line_w719");
        end

        scale_y_shift = 2'd1;
        cnt0 = fetch_cnt;
        req(12'd0);
        wait_busy(1'b1, "x2_fetch_src0");
        send_seg(16'h0200, 0, 16, 1'b1, 1'b0);
        req(12'd1);
        repeat (10) @(negedge aclk);
        check("x2_repeat_no_fetch", 32'(fetch_busy), 32'd0);
        req(12'd2);
        wait_busy(1'b1, "x2_fetch_src1");
        send_seg(16'h0201, 0, 16, 1'b1, 1'b0);
        req(12'd3);
        repeat (10) @(negedge aclk);
        check("x2_fetch_count", 32'(fetch_cnt - cnt0), 32'd2);
        do_read(1, 5, 32'h0201_0005, "x2_buf1_w5");
        scale_y_shift = 2'd0;

        req(12'd4);
        wait_busy(1'b1, "ovf_fetch_start");
        send_seg(16'h0300, 0, 1925, 1'b1, 1'b0);
        check("ovf_flag", 32'(err_overflow), 32'd1);
        check("ovf_busy", 32'(fetch_busy), 32'd0);
        do_read(0, 1919, 32'h0300_077F, "ovf_last_kept");
        do_read(1, 0, 32'h0201_0000, "ovf_no_spill");
        req(12'd5);
        wait_busy(1'b1, "post_ovf_fetch");
        send_seg(16'h0301, 0, 8, 1'b1, 1'b0);
        do_read(1, 7, 32'h0301_0007, "post_ovf_w7");
        check("ovf_sticky", 32'(err_overflow), 32'd1);
        @(negedge aclk);
        err_clear = 1'b1;
        @(negedge aclk);
        err_clear = 1'b0;
        check("ovf_cleared", 32'(err_overflow), 32'd0);

        req(12'd6);
        wait_busy(1'b1, "late_fetch_start");
        send_seg(16'h0306, 0, 4, 1'b0, 1'b0);
        req(12'd7);
        check("late_flag", 32'(err_late), 32'd1);
        check("late_still_busy", 32'(fetch_busy), 32'd1);
        send_seg(16'h0306, 4, 4, 1'b1, 1'b0);
        check("late_wait_gap", 32'(fetch_busy), 32'd0);
        @(negedge aclk);
        check("late_queued_start", 32'(fetch_busy), 32'd1);
        send_seg(16'h0307, 0, 8, 1'b1, 1'b0);
        do_read(0, 7, 32'h0306_0007, "late_line6_w7");
        do_read(1, 3, 32'h0307_0003, "late_line7_w3");

        @(negedge aclk);
        vsync_request = 1'b1;
        @(negedge aclk);
        vsync_request = 1'b0;
        check("vsync_idle_tready", 32'(vid.tready), 32'd1);
        req(12'd8);
        repeat (5) @(negedge aclk);
        check("vsync_idle_no_fetch", 32'(fetch_busy), 32'd0);
        send_seg(16'h03F0, 0, 3, 1'b0, 1'b0);
        do_read(0, 0, 32'h0306_0000, "idle_no_write");
        send_seg(16'h03AA, 0, 1, 1'b0, 1'b1);
        repeat (4) @(negedge aclk);
        req(12'd9);
        wait_busy(1'b1, "realign_fetch");
        send_seg(16'h0309, 0, 4, 1'b0, 1'b0);
        send_seg(16'h03AB, 0, 1, 1'b0, 1'b1);
        send_seg(16'h03AB, 1, 2, 1'b1, 1'b0);
        do_read(0, 0, 32'h03AB_0000, "midline_tuser_w0");
        do_read(0, 2, 32'h03AB_0002, "midline_tuser_w2");
        do_read(1, 3, 32'h0309_0003, "midline_pre_w3");

        check("late_before_rst", 32'(err_late), 32'd1);
        req(12'd10);
        wait_busy(1'b1, "rst_fetch_start");
        send_seg(16'h030A, 0, 3, 1'b0, 1'b0);
        aresetn = 1'b0;
        @(negedge aclk);
        check("midrst_tready", 32'(vid.tready), 32'd0);
        check("midrst_busy", 32'(fetch_busy), 32'd0);
        check("midrst_flags", {30'd0, err_overflow, err_late}, 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("midrst_idle", 32'(vid.tready), 32'd1);

        drain = 0;
        while (q_exp.size() != 0 && drain < 20) begin
            @(negedge rd_clk);
            drain++;
        end
        if (q_exp.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
